// File: rtl/sdram_read_master_pkg.sv
// rtl/sdram_read_master_pkg.sv - shared types and width helpers for the SDRAM read master
// Purpose: state enum for the read-master FSM and constant functions that derive
//          bytes-per-word and the address-increment shift from DATA_WIDTH.
package sdram_read_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } rm_state_e;

  function automatic int bytes_of(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int addr_shift_of(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/sdram_rm_fifo.sv
// rtl/sdram_rm_fifo.sv - show-ahead word FIFO for the SDRAM read master
// Purpose: synchronous show-ahead FIFO, DATA_WIDTH x FIFO_DEPTH.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   push_i/data_i  write one word (caller guarantees free space)
//   pop_i          drop the head word; ignored when empty
//   flush_i        empty the FIFO; dominates push and pop
//   used_o         words currently held
//   empty_o        no words held
//   head_o         current head word, zero while empty
module sdram_rm_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 32,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [CW-1:0]         used_o,
  output logic                  empty_o,
  output logic [DATA_WIDTH-1:0] head_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]         used_q;
  logic                  do_pop;

  assign empty_o = (used_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign used_o  = used_q;
  // Head is forced to zero while empty so the output is clean after reset/flush.
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      used_q   <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, do_pop})
        2'b10:   used_q <= used_q + CW'(1);
        2'b01:   used_q <= used_q - CW'(1);
        default: used_q <= used_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/sdram_read_master.sv
// rtl/sdram_read_master.sv - Avalon-MM pipelined block read master with show-ahead FIFO
// Purpose: streams a block of SDRAM words to a user pop port, optional circular repeat, abort.
// Optional feature macro: SDRAM_READ_MASTER_CIRCULAR_EN (circular re-read of the region).
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   control_*                     block setup (base, length in bytes, fixed, circular),
//                                 go/abort pulses, done / early_done status
//   user_read_buffer              pop the FIFO head
//   user_buffer_output_data       FIFO head (show-ahead), user_data_available = not empty
//   master_*                      Avalon-MM pipelined read master
module sdram_read_master
  import sdram_read_master_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 32,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    control_fixed_location,
  input  logic [ADDR_WIDTH-1:0]   control_read_base,
  input  logic [LEN_WIDTH-1:0]    control_read_length,
  input  logic                    control_circular,
  input  logic                    control_go,
  input  logic                    control_abort,
  output logic                    control_done,
  output logic                    control_early_done,
  input  logic                    user_read_buffer,
  output logic [DATA_WIDTH-1:0]   user_buffer_output_data,
  output logic                    user_data_available,
  output logic [ADDR_WIDTH-1:0]   master_address,
  output logic                    master_read,
  output logic [DATA_WIDTH/8-1:0] master_byteenable,
  input  logic [DATA_WIDTH-1:0]   master_readdata,
  input  logic                    master_waitrequest,
  input  logic                    master_readdatavalid
);

  localparam int BYTES = bytes_of(DATA_WIDTH);
  localparam int SHIFT = addr_shift_of(DATA_WIDTH);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LEN_WIDTH-1:0]  LEN_STEP     = LEN_WIDTH'(BYTES);
  localparam logic [LEN_WIDTH-1:0]  LEN_MASK     = ~(LEN_STEP - LEN_WIDTH'(1));
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP    = ADDR_WIDTH'(1) << SHIFT;
  localparam logic [CW:0]           INFLIGHT_MAX = (CW+1)'(FIFO_DEPTH);

  rm_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d, base_q;
  logic [LEN_WIDTH-1:0]   remaining_q, remaining_d, len_q, len_trunc;
  logic [CW-1:0]          pending_q, pending_d, fifo_used;
  logic [CW:0]            inflight;
  logic                   stall_q, stall_d, fixed_q, circ_en;
  logic                   fifo_empty, accept, abort_now, go_now;

  assign len_trunc = control_read_length & LEN_MASK;
  assign go_now    = (state_q == IDLE) && control_go;
  assign abort_now = control_abort && ((state_q == RUN) || (state_q == DRAIN));
  assign accept    = master_read && !master_waitrequest;
  // Reads in flight plus words buffered; capping this at FIFO_DEPTH reserves a slot per read.
  assign inflight  = {1'b0, pending_q} + {1'b0, fifo_used};

`ifdef SDRAM_READ_MASTER_CIRCULAR_EN
  logic circ_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       circ_q <= 1'b0;
    else if (go_now) circ_q <= control_circular;
  end
  assign circ_en = circ_q;
`else
  logic unused_circular;
  assign unused_circular = control_circular;
  assign circ_en = 1'b0;
`endif

  always_comb begin
    master_read = 1'b0;
    case (state_q)
      RUN:     master_read = (remaining_q != '0) && (inflight < INFLIGHT_MAX);
      FLUSH:   master_read = stall_q;  // a stalled read must stay up until accepted
      default: master_read = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    stall_d     = stall_q;
    case (state_q)
      IDLE: begin
        if (control_go) begin
          addr_d      = control_read_base;
          remaining_d = len_trunc;
          if (len_trunc != '0) state_d = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          if (!fixed_q) addr_d = addr_q + ADDR_STEP;
          remaining_d = remaining_q - LEN_STEP;
          if (remaining_q == LEN_STEP) begin
            // Last word of the region: reload in the same cycle so circular mode has no gap.
            if (circ_en) begin
              addr_d      = base_q;
              remaining_d = len_q;
            end else begin
              state_d = DRAIN;
            end
          end
        end
        if (control_abort) begin
          state_d = FLUSH;
          stall_d = master_read && master_waitrequest;
        end
      end
      DRAIN: begin
        if (control_abort) begin
          state_d = FLUSH;
          stall_d = 1'b0;
        end else if ((pending_q == '0) && fifo_empty) begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (accept) stall_d = 1'b0;
        if ((pending_q == '0) && !stall_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    if (accept && !master_readdatavalid)      pending_d = pending_q + CW'(1);
    else if (!accept && master_readdatavalid) pending_d = pending_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      pending_q   <= '0;
      stall_q     <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      fixed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      pending_q   <= pending_d;
      stall_q     <= stall_d;
      if (go_now) begin
        base_q  <= control_read_base;
        len_q   <= len_trunc;
        fixed_q <= control_fixed_location;
      end
    end
  end

  sdram_rm_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (master_readdatavalid && (state_q != FLUSH)),
    .push_data_i (master_readdata),
    .pop_i       (user_read_buffer),
    .flush_i     (abort_now || (state_q == FLUSH)),
    .used_o      (fifo_used),
    .empty_o     (fifo_empty),
    .head_o      (user_buffer_output_data)
  );

  assign user_data_available = !fifo_empty;
  assign master_address      = addr_q;
  assign master_byteenable   = '1;
  assign control_done        = (state_q == IDLE);
  assign control_early_done  = (state_q == IDLE) || (state_q == DRAIN);

endmodule

// File: tb/tb_sdram_read_master.sv
// tb/tb_sdram_read_master.sv - self-checking bench for sdram_read_master
module tb_sdram_read_master;

  localparam int DEPTH = 4;
`ifdef SDRAM_READ_MASTER_CIRCULAR_EN
  localparam bit CIRC_EN = 1'b1;
`else
  localparam bit CIRC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        control_fixed_location = 1'b0;
  logic [31:0] control_read_base = '0;
  logic [31:0] control_read_length = '0;
  logic        control_circular = 1'b0;
  logic        control_go = 1'b0;
  logic        control_abort = 1'b0;
  logic        control_done, control_early_done;
  logic        user_read_buffer = 1'b0;
  logic [15:0] user_buffer_output_data;
  logic        user_data_available;
  logic [31:0] master_address;
  logic        master_read;
  logic [1:0]  master_byteenable;
  logic [15:0] master_readdata = '0;
  logic        master_waitrequest = 1'b0;
  logic        master_readdatavalid = 1'b0;

  always #5 clk = ~clk;

  sdram_read_master #(
    .DATA_WIDTH (16), .ADDR_WIDTH (32), .LEN_WIDTH (32), .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .control_fixed_location  (control_fixed_location),
    .control_read_base       (control_read_base),
    .control_read_length     (control_read_length),
    .control_circular        (control_circular),
    .control_go              (control_go),
    .control_abort           (control_abort),
    .control_done            (control_done),
    .control_early_done      (control_early_done),
    .user_read_buffer        (user_read_buffer),
    .user_buffer_output_data (user_buffer_output_data),
    .user_data_available     (user_data_available),
    .master_address          (master_address),
    .master_read             (master_read),
    .master_byteenable       (master_byteenable),
    .master_readdata         (master_readdata),
    .master_waitrequest      (master_waitrequest),
    .master_readdatavalid    (master_readdatavalid)
  );

  typedef struct { logic [15:0] d; int due; } rsp_t;

  int          n_checks = 0;
  int          n_err = 0;
  rsp_t        sq[$];          // slave: accepted reads awaiting return
  logic [15:0] mq[$];          // model of the user-visible FIFO contents
  logic [31:0] m_base = '0;
  int          m_words = 0;
  int          m_acc = 0;
  bit          m_fixed = 1'b0;
  bit          m_circ = 1'b0;
  int          wait_pct = 0, pop_pct = 0, lat_max = 1;
  bit          script = 1'b0;
  int          stall_cnt = 0;
  bit          flushing = 1'b0;
  int          flush_cyc = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] acc_addr [256];
  int          acc_cyc [256];
  int          cyc = 0;
  logic [31:0] rbase, rlen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] memdata(input logic [31:0] a);
    return (a[15:0] * 16'd7) ^ 16'hA55A;
  endfunction

  // k-th accepted read address of the current transfer
  function automatic logic [31:0] exp_addr(input int k);
    int idx;
    idx = (m_circ && m_words > 0) ? (k % m_words) : k;
    if (m_fixed) return m_base;
    return m_base + 32'(idx) * 32'd2;
  endfunction

  // Slave, user and scoreboard: decides inputs for the coming edge and checks outputs.
  always @(negedge clk) begin
    bit          pop, rdv;
    logic [15:0] rd;
    if (reset) begin
      sq.delete();
      mq.delete();
      master_waitrequest   = 1'b0;
      master_readdatavalid = 1'b0;
      user_read_buffer     = 1'b0;
      prev_stall           = 1'b0;
    end else begin
      cyc++;
      if (!flushing) begin
        chk("data_available", 64'(user_data_available), 64'(mq.size() != 0));
        if (mq.size() != 0) chk("head_data", 64'(user_buffer_output_data), 64'(mq[0]));
        if (master_read && !prev_stall)
          chk("reservation", 64'(sq.size() + mq.size() < DEPTH), 64'(1));
      end else begin
        if (flush_cyc > 0 && master_read) chk("read_after_abort_held", 64'(prev_stall), 64'(1));
        flush_cyc++;
      end
      if (prev_stall) begin
        chk("stall_hold_read", 64'(master_read), 64'(1));
        chk("stall_hold_addr", 64'(master_address), 64'(prev_addr));
      end

      if (script && m_acc == 1 && master_read && stall_cnt < 3) begin
        master_waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        master_waitrequest = (int'($urandom_range(99)) < wait_pct);
      end

      if (sq.size() != 0 && sq[0].due <= cyc) begin
        rdv = 1'b1;
        rd  = sq[0].d;
        sq.delete(0);
      end else begin
        rdv = 1'b0;
        rd  = 16'($urandom);
      end
      master_readdatavalid = rdv;
      master_readdata      = rd;

      pop = (int'($urandom_range(99)) < pop_pct);
      user_read_buffer = pop;

      if (master_read && !master_waitrequest) begin
        chk("read_address", 64'(master_address), 64'(exp_addr(m_acc)));
        if (!m_circ) chk("read_within_length", 64'(m_acc < m_words), 64'(1));
        if (m_acc < 256) begin
          acc_addr[m_acc] = master_address;
          acc_cyc[m_acc]  = cyc;
        end
        sq.push_back('{d: memdata(master_address), due: cyc + int'($urandom_range(lat_max, 1))});
        m_acc++;
      end

      if (flushing) begin
        mq.delete();
      end else begin
        if (pop && mq.size() != 0) mq.delete(0);
        if (rdv) mq.push_back(rd);
      end
      prev_stall = master_read && master_waitrequest;
      prev_addr  = master_address;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start(input logic [31:0] base, input logic [31:0] len, input bit fixed, input bit circ);
    m_base  = base;
    m_words = int'(len >> 1);
    m_fixed = fixed;
    m_circ  = circ && CIRC_EN;
    m_acc   = 0;
    control_read_base      = base;
    control_read_length    = len;
    control_fixed_location = fixed;
    control_circular       = circ;
    control_go = 1'b1;
    tick();
    control_go = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    i = 0;
    while (!control_done && i < budget) begin
      tick();
      i++;
    end
    chk({name, "_done"}, 64'(control_done), 64'(1));
    chk({name, "_no_outstanding"}, 64'(sq.size()), 64'(0));
    chk({name, "_fifo_empty"}, 64'(user_data_available), 64'(0));
  endtask

  task automatic abort_and_wait(input string name);
    flushing  = 1'b1;
    flush_cyc = 0;
    control_abort = 1'b1;
    tick();
    control_abort = 1'b0;
    wait_done(name, 100);
    flushing = 1'b0;
  endtask

  initial begin
    // reset values
    repeat (3) tick();
    chk("rst_done", 64'(control_done), 64'(1));
    chk("rst_early_done", 64'(control_early_done), 64'(1));
    chk("rst_read", 64'(master_read), 64'(0));
    chk("rst_addr", 64'(master_address), 64'(0));
    chk("rst_avail", 64'(user_data_available), 64'(0));
    chk("rst_data", 64'(user_buffer_output_data), 64'(0));
    chk("rst_byteenable", 64'(master_byteenable), 64'(2'b11));
    reset = 1'b0;
    tick();

    // length 0 and length 1 (truncates to 0): nothing issued, done stays high
    start(32'h80, 32'd0, 1'b0, 1'b0);
    repeat (4) begin
      chk("len0_read", 64'(master_read), 64'(0));
      chk("len0_done", 64'(control_done), 64'(1));
      tick();
    end
    start(32'h80, 32'd1, 1'b0, 1'b0);
    chk("len1_done", 64'(control_done), 64'(1));

    // abort in IDLE is ignored
    control_abort = 1'b1;
    tick();
    control_abort = 1'b0;
    chk("idle_abort_done", 64'(control_done), 64'(1));
    chk("idle_abort_read", 64'(master_read), 64'(0));

    // linear read, four words back to back
    wait_pct = 0; pop_pct = 0; lat_max = 1;
    start(32'h100, 32'd8, 1'b0, 1'b0);
    chk("go_read_next", 64'(master_read), 64'(1));
    chk("go_done_low", 64'(control_done), 64'(0));
    chk("run_early_low", 64'(control_early_done), 64'(0));
    for (int i = 0; i < 20 && m_acc < 4; i++) tick();
    chk("lin_early_done", 64'(control_early_done), 64'(1));
    chk("lin_addr3", 64'(acc_addr[3]), 64'(32'h106));
    chk("lin_back_to_back", 64'(acc_cyc[3] - acc_cyc[0]), 64'(3));
    pop_pct = 100;
    wait_done("linear", 50);
    chk("lin_count", 64'(m_acc), 64'(4));

    // backpressure: no pops, depth 4
    pop_pct = 0; lat_max = 3;
    start(32'h200, 32'd32, 1'b0, 1'b0);
    repeat (40) tick();
    chk("bp_read_stopped", 64'(master_read), 64'(0));
    chk("bp_reads_issued", 64'(m_acc), 64'(4));
    chk("bp_avail", 64'(user_data_available), 64'(1));
    pop_pct = 60;
    wait_done("backpressure", 400);
    chk("bp_count", 64'(m_acc), 64'(16));

    // waitrequest for 3 cycles on the second read
    pop_pct = 100; lat_max = 1; script = 1'b1; stall_cnt = 0;
    start(32'h100, 32'd8, 1'b0, 1'b0);
    wait_done("waitreq", 100);
    script = 1'b0;
    chk("wr_stalls", 64'(stall_cnt), 64'(3));
    chk("wr_addr1", 64'(acc_addr[1]), 64'(32'h102));
    chk("wr_gap", 64'(acc_cyc[1] - acc_cyc[0]), 64'(4));
    chk("wr_count", 64'(m_acc), 64'(4));

    // fixed location
    start(32'h300, 32'd6, 1'b1, 1'b0);
    wait_done("fixed", 100);
    chk("fixed_count", 64'(m_acc), 64'(3));
    chk("fixed_addr2", 64'(acc_addr[2]), 64'(32'h300));

    // go and abort together in IDLE: go wins
    control_abort = 1'b1;
    start(32'h500, 32'd4, 1'b0, 1'b0);
    control_abort = 1'b0;
    chk("go_wins_read", 64'(master_read), 64'(1));
    wait_done("go_wins", 100);

    // randomized transfers, first one wraps the address space
    for (int t = 0; t < 8; t++) begin
      wait_pct = 30;
      pop_pct  = int'($urandom_range(90, 20));
      lat_max  = int'($urandom_range(4, 1));
      rbase = (t == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFE);
      rlen  = (t == 0) ? 32'd20 : 32'($urandom_range(40, 0));
      start(rbase, rlen, 1'($urandom_range(1, 0)), 1'b0);
      wait_done("random", 800);
      chk("random_count", 64'(m_acc), 64'(m_words));
    end

    // circular then abort
    wait_pct = 0; pop_pct = 100; lat_max = 1;
    start(32'h40, 32'd4, 1'b0, 1'b1);
    if (CIRC_EN) begin
      repeat (20) begin
        chk("circ_early_low", 64'(control_early_done), 64'(0));
        chk("circ_done_low", 64'(control_done), 64'(0));
        tick();
      end
      chk("circ_a0", 64'(acc_addr[0]), 64'(32'h40));
      chk("circ_a1", 64'(acc_addr[1]), 64'(32'h42));
      chk("circ_a2", 64'(acc_addr[2]), 64'(32'h40));
      chk("circ_a3", 64'(acc_addr[3]), 64'(32'h42));
      abort_and_wait("circ_abort");
    end else begin
      wait_done("circ_disabled", 100);
      chk("circ_disabled_count", 64'(m_acc), 64'(2));
    end

    // abort a long linear transfer under random waitrequest
    wait_pct = 40; pop_pct = 50; lat_max = 3;
    start(32'h1000, 32'd200, 1'b0, 1'b0);
    repeat (12) tick();
    abort_and_wait("abort");
    chk("abort_partial", 64'(m_acc < m_words), 64'(1));

    // reset mid-transfer clears outputs immediately
    wait_pct = 0; pop_pct = 0;
    start(32'h2000, 32'd40, 1'b0, 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_read", 64'(master_read), 64'(0));
    chk("mid_rst_addr", 64'(master_address), 64'(0));
    chk("mid_rst_done", 64'(control_done), 64'(1));
    chk("mid_rst_early", 64'(control_early_done), 64'(1));
    chk("mid_rst_avail", 64'(user_data_available), 64'(0));
    chk("mid_rst_data", 64'(user_buffer_output_data), 64'(0));
    tick();
    reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
